aes_stream_engine: RTL



---
 rtl/aes_stream_pkg.sv | 144 ++++++++++++++
 rtl/aes_cores.sv | 58 +++++
 rtl/aes_out_fifo.sv | 56 +++++
 rtl/aes_stream_engine.sv | 139 +++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and AES round helpers for the streaming AES-128 engine.
package aes_stream_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic {
    MODE_ECB,
    MODE_CBC
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_STREAM
  } state_e;

  typedef struct packed {
    block_t data;
    logic   last;
  } fifo_entry_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
      ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic block_t sub_bytes(
    input block_t s,
    input logic   inv
  );
    block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (inv) r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      else     r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic block_t shift_rows(
    input block_t s,
    input logic   inv
  );
    block_t r;
    int     sc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        sc = inv ? (c + 4 - rw) % 4 : (c + rw) % 4;
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*sc+rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic block_t mix_cols(
    input block_t s,
    input logic   inv
  );
    block_t     r;
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (!inv) begin
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        b0 = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11)
           ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
        b1 = gf_mul(a0, 8'd9) ^ gf_mul(a1, 8'd14)
           ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
        b2 = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)
           ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
        b3 = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13)
           ^ gf_mul(a2, 8'd9) ^ gf_mul(a3, 8'd14);
      end
      r[127-32*c -: 32] = {b0, b1, b2, b3};
    end
    return r;
  endfunction

  function automatic block_t next_key(
    input block_t     k,
    input logic [7:0] rc
  );
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]),
          sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_cores.sv
// Combinational AES-128 cipher and inverse cipher, keys expanded on the fly.
module AES_Encrypt
  import aes_stream_pkg::*;
(
  input  logic [127:0] blk,
  input  logic [127:0] key,
  output logic [127:0] res
);

  block_t     st;
  block_t     rk;
  logic [7:0] rc;

  always_comb begin
    rk = key;
    rc = 8'h01;
    st = blk ^ key;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, rc);
      rc = xtime(rc);
      st = shift_rows(sub_bytes(st, 1'b0), 1'b0);
      if (r != 10) st = mix_cols(st, 1'b0);
      st = st ^ rk;
    end
    res = st;
  end

endmodule

module AES_Decrypt
  import aes_stream_pkg::*;
(
  input  logic [127:0] blk,
  input  logic [127:0] key,
  output logic [127:0] res
);

  block_t     rks [11];
  block_t     st;
  logic [7:0] rc;

  always_comb begin
    rks[0] = key;
    rc     = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rks[r] = next_key(rks[r-1], rc);
      rc     = xtime(rc);
    end
    st = blk ^ rks[10];
    for (int r = 9; r >= 0; r--) begin
      st = sub_bytes(shift_rows(st, 1'b1), 1'b1);
      st = st ^ rks[r];
      if (r != 0) st = mix_cols(st, 1'b1);
    end
    res = st;
  end

endmodule

// File: rtl/aes_out_fifo.sv
// Synchronous output FIFO holding finished blocks and their last flags.
module aes_out_fifo
  import aes_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fifo_entry_t                   wr_entry,
  input  logic                          pop,
  output fifo_entry_t                   rd_entry,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);

  fifo_entry_t   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == DEPTH_L);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/aes_stream_engine.sv
// Streaming AES-128 ECB/CBC engine: one-block stage, chain register, output FIFO.
module aes_stream_engine
  import aes_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit CBC_EN     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_mode,
  input  logic         cfg_encrypt,
  output logic         err_cfg,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  state_e      state_q, state_d;
  block_t      key_q, iv_q, chain_q, stage_q;
  mode_e       mode_q;
  logic        enc_q, stage_vld_q, stage_last_q, err_q;
  block_t      enc_in, enc_out, dec_out, res;
  logic        cbc, last_pending, credit_ok, accept, cfg_ok;
  logic [CW-1:0] fifo_count;
  logic [CW:0] used;
  logic        fifo_full, fifo_empty;
  fifo_entry_t head;

  assign cbc    = (mode_q == MODE_CBC);
  assign enc_in = stage_q ^ (cbc ? chain_q : '0);

  AES_Encrypt u_enc (
    .blk (enc_in),
    .key (key_q),
    .res (enc_out)
  );

  AES_Decrypt u_dec (
    .blk (stage_q),
    .key (key_q),
    .res (dec_out)
  );

  always_comb begin
    res = dec_out;
    if (enc_q)    res = enc_out;
    else if (cbc) res = dec_out ^ chain_q;
  end

  // Credit counts the staged block so its retire never finds the FIFO full
  assign used         = {1'b0, fifo_count} + {{CW{1'b0}}, stage_vld_q};
  assign credit_ok    = (used < DEPTH_L) && !fifo_full;
  assign last_pending = stage_vld_q && stage_last_q;
  assign in_ready     = (state_q != ST_IDLE) && !last_pending && credit_ok
                     && !(state_q == ST_ARMED && cfg_valid);
  assign accept       = in_valid && in_ready;
  assign cfg_ok       = cfg_valid && (state_q != ST_STREAM);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cfg_valid) state_d = ST_ARMED;
      ST_ARMED:  if (accept) state_d = ST_STREAM;
      ST_STREAM: if (last_pending) state_d = ST_ARMED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q        <= '0;
      iv_q         <= '0;
      chain_q      <= '0;
      stage_q      <= '0;
      mode_q       <= MODE_ECB;
      enc_q        <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_last_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q       <= cfg_valid && (state_q == ST_STREAM);
      stage_vld_q <= accept;
      if (cfg_ok) begin
        key_q  <= cfg_key;
        iv_q   <= cfg_iv;
        mode_q <= (CBC_EN && cfg_mode) ? MODE_CBC : MODE_ECB;
        enc_q  <= cfg_encrypt;
      end
      if (accept) begin
        stage_q      <= in_data;
        stage_last_q <= in_last;
      end
      if (cfg_ok) begin
        chain_q <= cfg_iv;
      end else if (stage_vld_q) begin
        if (stage_last_q) chain_q <= iv_q;
        else if (cbc)     chain_q <= enc_q ? res : stage_q;
      end
    end
  end

  aes_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stage_vld_q),
    .wr_entry ({res, stage_last_q}),
    .pop      (out_valid && out_ready),
    .rd_entry (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_last  = head.last;
  assign busy      = (state_q == ST_STREAM) || !fifo_empty;
  assign err_cfg   = err_q;

endmodule
